// File: rtl/tank_pkg.sv
// Shared types and screen constants for the tank game datapath.
package tank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FLY  = 2'd1,
    ST_COOL = 2'd2
  } bullet_state_t;

  typedef logic [9:0] coord_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int MARGIN   = 4;

endpackage

// File: rtl/frame_counter.sv
// Loadable up/down frame counter; done flags the count sitting at the terminal value.
module frame_counter #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         up,
  input  logic [W-1:0] term,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (en)
      count <= up ? count + W'(1) : count - W'(1);
  end

  assign done = (count == term);

endmodule

// File: rtl/bullet_motion.sv
// Per-tank bullet controller: spawn, wall reflection by sign forcing, lifetime,
// bounce limit and re-fire cooldown, updated once per frame.
module bullet_motion
  import tank_pkg::*;
#(
  parameter int BULLET_S    = 2,
  parameter int LIFETIME    = 300,
  parameter int MAX_BOUNCES = 5,
  parameter int COOLDOWN    = 30
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_tick,
  input  logic       fire,
  input  logic       hit,
  input  logic [9:0] TankX,
  input  logic [9:0] TankY,
  input  logic [9:0] DirX,
  input  logic [9:0] DirY,
  input  logic       isWallTop,
  input  logic       isWallBottom,
  input  logic       isWallLeft,
  input  logic       isWallRight,
  output logic [9:0] BulletX,
  output logic [9:0] BulletY,
  output logic [9:0] BulletS,
  output logic [9:0] X_Motion,
  output logic [9:0] Y_Motion,
  output logic       bullet_active,
  output logic [2:0] bounces
);

  localparam int LIFE_W = $clog2(LIFETIME + 1);
  localparam int COOL_W = $clog2(COOLDOWN + 1);

  // -512 has no positive twin in 10 bits, so it saturates to magnitude 511.
  function automatic logic signed [9:0] force_pos(input logic signed [9:0] v);
    if (v == 10'sh200) return 10'sh1FF;
    else if (v[9])     return -v;
    else               return v;
  endfunction

  function automatic logic signed [9:0] force_neg(input logic signed [9:0] v);
    if (v == 10'sh200)        return 10'sh201;
    else if (!v[9] && |v)     return -v;
    else                      return v;
  endfunction

  bullet_state_t state, state_nxt;
  coord_t        x_nxt, y_nxt;
  logic signed [9:0] xm_nxt, ym_nxt, xm_ref, ym_ref;
  logic [2:0]    bnc_nxt;
  logic          act_nxt, x_chg, y_chg, go_cool;
  logic          life_load, life_en, life_done, cool_load, cool_en, cool_done;

  assign BulletS = 10'(BULLET_S);

  always_comb begin
    xm_ref = $signed(X_Motion);
    ym_ref = $signed(Y_Motion);
    x_chg  = 1'b0;
    y_chg  = 1'b0;
    if (isWallLeft) begin
      xm_ref = force_pos($signed(X_Motion));
      x_chg  = X_Motion[9];
    end else if (isWallRight) begin
      xm_ref = force_neg($signed(X_Motion));
      x_chg  = !X_Motion[9] && |X_Motion;
    end
    if (isWallTop) begin
      ym_ref = force_pos($signed(Y_Motion));
      y_chg  = Y_Motion[9];
    end else if (isWallBottom) begin
      ym_ref = force_neg($signed(Y_Motion));
      y_chg  = !Y_Motion[9] && |Y_Motion;
    end
  end

  always_comb begin
    state_nxt = state;
    x_nxt     = BulletX;
    y_nxt     = BulletY;
    xm_nxt    = $signed(X_Motion);
    ym_nxt    = $signed(Y_Motion);
    bnc_nxt   = bounces;
    act_nxt   = bullet_active;
    go_cool   = 1'b0;
    life_load = 1'b0;
    life_en   = 1'b0;
    cool_load = 1'b0;
    cool_en   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (fire) begin
          state_nxt = ST_FLY;
          x_nxt     = TankX;
          y_nxt     = TankY;
          xm_nxt    = $signed(DirX);
          ym_nxt    = $signed(DirY);
          bnc_nxt   = '0;
          act_nxt   = 1'b1;
          life_load = 1'b1;
        end
      end
      ST_FLY: begin
        if (hit) begin
          go_cool = 1'b1;
        end else if (frame_tick) begin
          life_en = 1'b1;
          // The reflection that would exceed the limit freezes the bullet in place.
          if ((x_chg || y_chg) && bounces == 3'(MAX_BOUNCES)) begin
            go_cool = 1'b1;
          end else begin
            xm_nxt  = xm_ref;
            ym_nxt  = ym_ref;
            x_nxt   = BulletX + coord_t'(xm_ref);
            y_nxt   = BulletY + coord_t'(ym_ref);
            bnc_nxt = bounces + 3'((x_chg || y_chg) ? 1 : 0);
            go_cool = life_done;
          end
        end
      end
      ST_COOL: begin
        if (frame_tick) begin
          cool_en = 1'b1;
          if (cool_done) state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (go_cool) begin
      state_nxt = ST_COOL;
      xm_nxt    = '0;
      ym_nxt    = '0;
      act_nxt   = 1'b0;
      cool_load = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      BulletX       <= '0;
      BulletY       <= '0;
      X_Motion      <= '0;
      Y_Motion      <= '0;
      bounces       <= '0;
      bullet_active <= 1'b0;
    end else begin
      BulletX       <= x_nxt;
      BulletY       <= y_nxt;
      X_Motion      <= xm_nxt;
      Y_Motion      <= ym_nxt;
      bounces       <= bnc_nxt;
      bullet_active <= act_nxt;
    end
  end

  // Lifetime counts up from 0; done on the tick that brings it to LIFETIME.
  frame_counter #(.W(LIFE_W)) u_life (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .load     (life_load),
    .load_val ('0),
    .en       (life_en),
    .up       (1'b1),
    .term     (LIFE_W'(LIFETIME - 1)),
    .done     (life_done)
  );

  // Cooldown counts down from COOLDOWN; done on the tick that brings it to 0.
  frame_counter #(.W(COOL_W)) u_cool (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .load     (cool_load),
    .load_val (COOL_W'(COOLDOWN)),
    .en       (cool_en),
    .up       (1'b0),
    .term     (COOL_W'(1)),
    .done     (cool_done)
  );

endmodule

// File: tb/tb_bullet_motion.sv
// Directed bench for bullet_motion with hand-computed expectations.
module tb_bullet_motion;

  logic       Clk = 1'b0;
  logic       Reset_n, frame_tick, fire, hit;
  logic [9:0] TankX, TankY, DirX, DirY;
  logic       isWallTop, isWallBottom, isWallLeft, isWallRight;
  logic [9:0] BulletX, BulletY, BulletS, X_Motion, Y_Motion;
  logic       bullet_active;
  logic [2:0] bounces;

  int vectors = 0;
  int miscompares = 0;

  bullet_motion dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .frame_tick    (frame_tick),
    .fire          (fire),
    .hit           (hit),
    .TankX         (TankX),
    .TankY         (TankY),
    .DirX          (DirX),
    .DirY          (DirY),
    .isWallTop     (isWallTop),
    .isWallBottom  (isWallBottom),
    .isWallLeft    (isWallLeft),
    .isWallRight   (isWallRight),
    .BulletX       (BulletX),
    .BulletY       (BulletY),
    .BulletS       (BulletS),
    .X_Motion      (X_Motion),
    .Y_Motion      (Y_Motion),
    .bullet_active (bullet_active),
    .bounces       (bounces)
  );

  always #5 Clk = ~Clk;

  function automatic logic [9:0] m(input int v);
    logic [31:0] t;
    t = v;
    return t[9:0];
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic tick(input logic l, input logic r, input logic t, input logic b);
    isWallLeft = l; isWallRight = r; isWallTop = t; isWallBottom = b;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    isWallLeft = 0; isWallRight = 0; isWallTop = 0; isWallBottom = 0;
  endtask

  task automatic respawn(input int x, input int y, input int dx, input int dy);
    Reset_n = 1'b0;
    #2;
    Reset_n = 1'b1;
    TankX = m(x); TankY = m(y); DirX = m(dx); DirY = m(dy);
    fire = 1'b1;
    step();
    fire = 1'b0;
  endtask

  initial begin
    Reset_n = 0; frame_tick = 0; fire = 0; hit = 0;
    TankX = 0; TankY = 0; DirX = 0; DirY = 0;
    isWallTop = 0; isWallBottom = 0; isWallLeft = 0; isWallRight = 0;
    step(); step();
    chk("rst_x", BulletX, 0);
    chk("rst_y", BulletY, 0);
    chk("rst_xm", X_Motion, 0);
    chk("rst_ym", Y_Motion, 0);
    chk("rst_active", bullet_active, 0);
    chk("rst_bounces", bounces, 0);
    chk("bullet_s", BulletS, 2);
    Reset_n = 1;
    step();

    // spawn and first frame
    TankX = 100; TankY = 200; DirX = m(3); DirY = m(-2); fire = 1;
    step();
    fire = 0;
    chk("spawn_x", BulletX, 100);
    chk("spawn_y", BulletY, 200);
    chk("spawn_xm", X_Motion, m(3));
    chk("spawn_ym", Y_Motion, m(-2));
    chk("spawn_active", bullet_active, 1);
    tick(0, 0, 0, 0);
    chk("move_x", BulletX, 103);
    chk("move_y", BulletY, 198);
    chk("move_active", bullet_active, 1);
    step();
    chk("hold_x", BulletX, 103);

    // left wall held two ticks: only one bounce
    respawn(100, 100, -3, 0);
    tick(1, 0, 0, 0);
    chk("left1_xm", X_Motion, m(3));
    chk("left1_x", BulletX, 103);
    chk("left1_bnc", bounces, 1);
    tick(1, 0, 0, 0);
    chk("left2_xm", X_Motion, m(3));
    chk("left2_x", BulletX, 106);
    chk("left2_bnc", bounces, 1);

    // corner: both axes flip, one bounce
    respawn(300, 300, 2, 2);
    tick(0, 1, 0, 1);
    chk("corner_xm", X_Motion, m(-2));
    chk("corner_ym", Y_Motion, m(-2));
    chk("corner_x", BulletX, 298);
    chk("corner_y", BulletY, 298);
    chk("corner_bnc", bounces, 1);

    // -512 saturates to +511 on a left reflection
    respawn(100, 50, -512, 0);
    tick(1, 0, 0, 0);
    chk("sat_xm", X_Motion, m(511));
    chk("sat_x", BulletX, 611);
    chk("sat_bnc", bounces, 1);

    // position wraps modulo 1024
    respawn(1020, 5, 10, -8);
    tick(0, 0, 0, 0);
    chk("wrap_x", BulletX, 6);
    chk("wrap_y", BulletY, 1021);

    // top wall on upward motion; no-change reflection on right wall with X=0
    respawn(40, 40, 0, -5);
    tick(0, 1, 1, 0);
    chk("top_ym", Y_Motion, m(5));
    chk("top_xm", X_Motion, 0);
    chk("top_y", BulletY, 45);
    chk("top_bnc", bounces, 1);

    // bounce limit: sixth reflection expires the bullet in place
    respawn(500, 500, -4, 0);
    for (int i = 1; i <= 5; i++) begin
      tick(i % 2 == 1, i % 2 == 0, 0, 0);
    end
    chk("lim5_bnc", bounces, 5);
    chk("lim5_x", BulletX, 504);
    chk("lim5_active", bullet_active, 1);
    tick(0, 1, 0, 0);
    chk("lim6_active", bullet_active, 0);
    chk("lim6_x", BulletX, 504);
    chk("lim6_xm", X_Motion, 0);
    chk("lim6_ym", Y_Motion, 0);

    // lifetime expiry, then cooldown blocks fire for 29 ticks
    respawn(0, 0, 1, 0);
    for (int i = 1; i <= 299; i++) tick(0, 0, 0, 0);
    chk("life299_active", bullet_active, 1);
    chk("life299_x", BulletX, 299);
    tick(0, 0, 0, 0);
    chk("life300_active", bullet_active, 0);
    chk("life300_x", BulletX, 300);
    chk("life300_xm", X_Motion, 0);
    TankX = 7; TankY = 8; DirX = m(5); DirY = m(6);
    for (int i = 1; i <= 29; i++) begin
      fire = 1;
      tick(0, 0, 0, 0);
      step();
      fire = 0;
      chk("cool_fire_ignored", bullet_active, 0);
    end
    chk("cool_x_held", BulletX, 300);
    tick(0, 0, 0, 0);
    chk("cool30_active", bullet_active, 0);
    fire = 1;
    step();
    fire = 0;
    chk("refire_active", bullet_active, 1);
    chk("refire_x", BulletX, 7);
    chk("refire_ym", Y_Motion, 6);

    // hit beats frame_tick and wall
    hit = 1;
    tick(0, 0, 1, 0);
    hit = 0;
    chk("hit_active", bullet_active, 0);
    chk("hit_x", BulletX, 7);
    chk("hit_y", BulletY, 8);
    chk("hit_xm", X_Motion, 0);
    chk("hit_ym", Y_Motion, 0);
    chk("hit_bnc", bounces, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    Reset_n = 0;
    #1;
    chk("areset_x", BulletX, 0);
    chk("areset_y", BulletY, 0);
    step();
    Reset_n = 1;
    step();

    // fire together with frame_tick in IDLE: spawn only
    TankX = 50; TankY = 60; DirX = m(4); DirY = m(-1); fire = 1;
    tick(0, 0, 0, 0);
    fire = 0;
    chk("idle_fire_x", BulletX, 50);
    chk("idle_fire_y", BulletY, 60);
    chk("idle_fire_active", bullet_active, 1);
    tick(0, 0, 0, 0);
    chk("after_x", BulletX, 54);
    chk("after_y", BulletY, 59);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
